dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single data-memory port between the CPU memory stage and one external master (program/data loader, display reader).
- The CPU has priority by default.
- A starvation counter forces an external ownership window of bounded length.
- CPU accesses keep the combinational read path the memory stage already registers. External reads return registered data with a valid pulse.

Parameters:
AW, 19, address width of the data-memory port
DW, 19, data width of the data-memory port
MAX_WAIT, 8, cycles an external request may be denied before ownership is forced to the external master (legal range 1..255)
MAX_BURST, 4, maximum external accesses per forced ownership window (legal range 1..255)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
cpu_req  in  1  CPU memory access this cycle (load or store)
cpu_we  in  1  CPU store
cpu_addr  in  AW  CPU address
cpu_wdata  in  DW  CPU store data
cpu_rdata  out  DW  read data to CPU, combinational from mem_rdata
cpu_stall  out  1  CPU access denied this cycle; pipeline must hold
ext_req  in  1  external access request
ext_we  in  1  external write
ext_addr  in  AW  external address
ext_wdata  in  DW  external write data
ext_last  in  1  final access of the external burst
ext_gnt  out  1  external access performed this cycle
ext_rvalid  out  1  registered pulse, ext_rdata valid
ext_rdata  out  DW  registered external read data
mem_we  out  1  data-memory write enable
mem_addr  out  AW  data-memory address
mem_wdata  out  DW  data-memory write data
mem_rdata  in  DW  data-memory read data (combinational w.r.t. mem_addr)

Behaviour:
- Interface: one clock, clk. rst is synchronous and active-high, sampled on the rising edge of clk.
- State register has two values: OWN_CPU and OWN_EXT. Also registered: wait_cnt (8 bit), burst_cnt (8 bit), ext_rvalid, ext_rdata.
- Reset values: state=OWN_CPU, wait_cnt=0, burst_cnt=0, ext_rvalid=0, ext_rdata=0.
- Combinational outputs after reset with no requests: cpu_stall=0, ext_gnt=0, mem_we=0.
- Grant in OWN_CPU:
  - CPU wins if cpu_req=1.
  - Otherwise the external master wins if ext_req=1 (opportunistic grant).
  - cpu_stall=0.
- Grant in OWN_EXT:
  - The external master wins if ext_req=1.
  - cpu_stall=cpu_req, even when ext_req=0 in that cycle.
- ext_gnt=1 exactly when the external master wins.
- Port mux:
  - The winner's addr, wdata and we drive the mem_* outputs.
  - mem_we=winner_we only when there is a winner.
  - With no winner, mem_addr=cpu_addr, mem_wdata=cpu_wdata, mem_we=0.
  - A denied requester never causes a write.
- cpu_rdata=mem_rdata at all times. It is meaningful only when the CPU is not stalled.
- wait_cnt, in OWN_CPU:
  - Clears on any ext_gnt, or when ext_req=0.
  - Increments when ext_req=1 and the request is denied.
  - If the counter is denied while at MAX_WAIT-1: next state=OWN_EXT, wait_cnt=0, burst_cnt=0.
- OWN_EXT window:
  - burst_cnt increments on each ext_gnt.
  - Return to OWN_CPU (burst_cnt=0) after a granted access with ext_last=1, or after a granted access that makes burst_cnt reach MAX_BURST.
  - Also return to OWN_CPU when ext_req=0 for a cycle. No grant occurs that cycle; the CPU stays stalled that cycle.
- Opportunistic grants in OWN_CPU neither change state nor count toward burst_cnt.
- External reads:
  - A granted read (ext_gnt=1, ext_we=0) captures mem_rdata into ext_rdata.
  - ext_rvalid=1 on the following cycle for exactly one cycle. Back-to-back reads give back-to-back pulses.
  - Writes produce no rvalid.
  - ext_rdata holds its value otherwise.
- Simultaneous cpu_req and ext_req in OWN_CPU: CPU wins, and the denial counts toward wait_cnt.
- Reset mid-window: state returns to OWN_CPU and both counters clear. ext_rvalid=0 on the cycle after reset even if a read was granted in the reset cycle; the grant in the reset cycle is combinational and may still occur.
- No combinational path from cpu_stall to cpu_req is assumed. The CPU holds its request while stalled.

Test Plan:
- Reset, then cpu_req=1, cpu_we=1, cpu_addr=0x00010, cpu_wdata=0x1ABCD; next cycle a CPU read of 0x00010 -> mem_we=1 then 0, cpu_rdata=0x1ABCD, cpu_stall=0 throughout.
- cpu_req=0, ext_req=1 read of 0x00020 (memory holds 0x00055) -> ext_gnt=1 same cycle; next cycle ext_rvalid=1, ext_rdata=0x00055; state stays OWN_CPU.
- cpu_req=1 and ext_req=1 held continuously, MAX_WAIT=8 -> ext denied for 8 cycles. Cycle 9: ext_gnt=1, cpu_stall=1, for 4 grants (MAX_BURST=4, ext_last=0). Cycle 13: CPU regains the port, cpu_stall=0.
- Forced window, ext_last=1 on the 2nd granted write -> exactly 2 memory writes; CPU stalled for 2 cycles, then resumes.
- Forced window, ext_req dropped after 1 grant -> one idle cycle with cpu_stall=1, mem_we=0; then OWN_CPU.
- rst=1 asserted mid-window with a read granted in that cycle -> next cycle state=OWN_CPU, ext_rvalid=0, wait_cnt=0, burst_cnt=0, cpu_stall=0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data-memory port between the CPU memory
// stage and one external master. The CPU has priority until the external
// master has been denied MAX_WAIT cycles in a row; it then owns the port for
// a window of at most MAX_BURST accesses.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   cpu_req/we/addr/wdata          CPU memory-stage access
//   cpu_rdata                      read data to CPU (combinational from mem_rdata)
//   cpu_stall                      CPU access denied this cycle
//   ext_req/we/addr/wdata/last     external master access, last = end of burst
//   ext_gnt                        external access performed this cycle
//   ext_rvalid, ext_rdata          registered external read return
//   mem_we/addr/wdata, mem_rdata   data-memory port
module dmem_arbiter #(
  parameter int unsigned AW        = 19,
  parameter int unsigned DW        = 19,
  parameter int unsigned MAX_WAIT  = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          ext_req,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_wdata,
  input  logic          ext_last,
  output logic          ext_gnt,
  output logic          ext_rvalid,
  output logic [DW-1:0] ext_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned CW = 8;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_EXT = 1'b1
  } own_e;

  own_e          r_state;
  own_e          w_state_nxt;
  logic [CW-1:0] r_wait_cnt;
  logic [CW-1:0] w_wait_nxt;
  logic [CW-1:0] r_burst_cnt;
  logic [CW-1:0] w_burst_nxt;
  logic          w_cpu_win;
  logic          w_ext_win;
  logic          w_cpu_stall;
  logic          w_ext_rd;
  logic          r_ext_rvalid;
  logic [DW-1:0] r_ext_rdata;

  // Ownership state and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= OWN_CPU;
      r_wait_cnt  <= '0;
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_wait_cnt  <= w_wait_nxt;
      r_burst_cnt <= w_burst_nxt;
    end
  end

  // Winner selection and next ownership
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    w_burst_nxt = r_burst_cnt;
    w_cpu_win   = 1'b0;
    w_ext_win   = 1'b0;
    w_cpu_stall = 1'b0;
    case (r_state)
      OWN_CPU: begin
        w_cpu_win = cpu_req;
        w_ext_win = ext_req & ~cpu_req;
        // Only a denied external request builds up starvation credit.
        if (ext_req && cpu_req) begin
          if (r_wait_cnt == CW'(MAX_WAIT - 1)) begin
            w_state_nxt = OWN_EXT;
            w_wait_nxt  = '0;
            w_burst_nxt = '0;
          end else begin
            w_wait_nxt = r_wait_cnt + CW'(1);
          end
        end else begin
          w_wait_nxt = '0;
        end
      end
      OWN_EXT: begin
        w_ext_win   = ext_req;
        w_cpu_stall = cpu_req;
        w_wait_nxt  = '0;
        // A cycle without ext_req ends the window with no grant.
        if (ext_req) begin
          if (ext_last || (r_burst_cnt == CW'(MAX_BURST - 1))) begin
            w_state_nxt = OWN_CPU;
            w_burst_nxt = '0;
          end else begin
            w_burst_nxt = r_burst_cnt + CW'(1);
          end
        end else begin
          w_state_nxt = OWN_CPU;
          w_burst_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = OWN_CPU;
      end
    endcase
  end

  // Port mux: CPU side is the idle default, writes only from the winner
  assign mem_we    = w_ext_win ? ext_we    : (w_cpu_win & cpu_we);
  assign mem_addr  = w_ext_win ? ext_addr  : cpu_addr;
  assign mem_wdata = w_ext_win ? ext_wdata : cpu_wdata;

  assign cpu_rdata = mem_rdata;
  assign cpu_stall = w_cpu_stall;
  assign ext_gnt   = w_ext_win;

  assign w_ext_rd  = w_ext_win & ~ext_we;

  // External read return: one-cycle valid pulse, data held between reads
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ext_rvalid <= 1'b0;
      r_ext_rdata  <= '0;
    end else begin
      r_ext_rvalid <= w_ext_rd;
      if (w_ext_rd) begin
        r_ext_rdata <= mem_rdata;
      end
    end
  end

  assign ext_rvalid = r_ext_rvalid;
  assign ext_rdata  = r_ext_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios plus randomized traffic,
// checked cycle by cycle against an ownership/starvation model.
module tb_dmem_arbiter;

  localparam int unsigned AW        = 19;
  localparam int unsigned DW        = 19;
  localparam int unsigned MAX_WAIT  = 8;
  localparam int unsigned MAX_BURST = 4;

  logic          clk;
  logic          rst;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  logic          ext_req;
  logic          ext_we;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata;
  logic          ext_last;
  logic          ext_gnt;
  logic          ext_rvalid;
  logic [DW-1:0] ext_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // Environment memory (256 words, address aliased on the low byte)
  logic [DW-1:0] tb_mem [256];
  // Reference copy updated only from the model's expected writes
  logic [DW-1:0] ref_mem [256];

  int n_checks;
  int n_errors;
  int cyc_no;

  // Model state: who owns the port, how long ext has starved, window use
  bit            m_ext_own;
  int            m_streak;
  int            m_used;
  bit            m_rvalid;
  logic [DW-1:0] m_rdata;

  // Values observed during the most recent cycle
  logic          obs_gnt;
  logic          obs_stall;
  logic          obs_we;
  logic [DW-1:0] obs_rdata;

  dmem_arbiter #(
    .AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_last(ext_last), .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = tb_mem[mem_addr[7:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=0x%0h exp=0x%0h", tag, cyc_no, got, exp);
    end
  endtask

  // One clock cycle: drive, check combinational outputs, clock, check registers
  task automatic cyc(input logic r, input logic c_req, input logic c_we,
                     input logic [AW-1:0] c_addr, input logic [DW-1:0] c_wd,
                     input logic e_req, input logic e_we,
                     input logic [AW-1:0] e_addr, input logic [DW-1:0] e_wd,
                     input logic e_last);
    bit            cpu_win;
    bit            ext_win;
    bit            stall;
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wd;
    logic          s_we;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wd;
    @(negedge clk);
    rst = r; cpu_req = c_req; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wd;
    ext_req = e_req; ext_we = e_we; ext_addr = e_addr; ext_wdata = e_wd; ext_last = e_last;
    #2;
    cpu_win  = !m_ext_own && c_req;
    ext_win  = m_ext_own ? e_req : (e_req && !c_req);
    stall    = m_ext_own && c_req;
    exp_we   = ext_win ? e_we : (cpu_win ? c_we : 1'b0);
    exp_addr = ext_win ? e_addr : c_addr;
    exp_wd   = ext_win ? e_wd : c_wd;
    check_eq("cpu_stall", 32'(cpu_stall), 32'(stall));
    check_eq("ext_gnt",   32'(ext_gnt),   32'(ext_win));
    check_eq("mem_we",    32'(mem_we),    32'(exp_we));
    check_eq("mem_addr",  32'(mem_addr),  32'(exp_addr));
    check_eq("mem_wdata", 32'(mem_wdata), 32'(exp_wd));
    check_eq("cpu_rdata", 32'(cpu_rdata), 32'(ref_mem[exp_addr[7:0]]));
    obs_gnt = ext_gnt; obs_stall = cpu_stall; obs_we = mem_we; obs_rdata = cpu_rdata;
    s_we = mem_we; s_addr = mem_addr; s_wd = mem_wdata;
    @(posedge clk);
    #1;
    cyc_no++;
    if (s_we) tb_mem[s_addr[7:0]] = s_wd;
    if (r) begin
      m_ext_own = 1'b0; m_streak = 0; m_used = 0; m_rvalid = 1'b0; m_rdata = '0;
    end else begin
      m_rvalid = ext_win && !e_we;
      if (m_rvalid) m_rdata = ref_mem[e_addr[7:0]];
      if (!m_ext_own) begin
        if (e_req && !ext_win) begin
          m_streak++;
          if (m_streak == int'(MAX_WAIT)) begin
            m_ext_own = 1'b1; m_streak = 0; m_used = 0;
          end
        end else begin
          m_streak = 0;
        end
      end else if (ext_win) begin
        m_used++;
        if (e_last || m_used == int'(MAX_BURST)) begin
          m_ext_own = 1'b0; m_used = 0;
        end
      end else begin
        m_ext_own = 1'b0; m_used = 0;
      end
    end
    if (exp_we) ref_mem[exp_addr[7:0]] = exp_wd;
    check_eq("ext_rvalid", 32'(ext_rvalid), 32'(m_rvalid));
    check_eq("ext_rdata",  32'(ext_rdata),  32'(m_rdata));
  endtask

  // Deny the external master long enough to open a forced window
  task automatic starve(input logic e_we);
    for (int i = 0; i < int'(MAX_WAIT); i++)
      cyc(1'b0, 1'b1, 1'b0, 19'h00030, 19'h0, 1'b1, e_we, 19'h00040, 19'h0, 1'b0);
  endtask

  initial begin
    int n_w;
    int n_s;
    n_checks = 0; n_errors = 0; cyc_no = 0;
    m_ext_own = 1'b0; m_streak = 0; m_used = 0; m_rvalid = 1'b0; m_rdata = '0;
    for (int i = 0; i < 256; i++) begin
      tb_mem[i]  = 19'(i * 37 + 5);
      ref_mem[i] = 19'(i * 37 + 5);
    end
    tb_mem[8'h20]  = 19'h00055;
    ref_mem[8'h20] = 19'h00055;
    rst = 1'b1; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    ext_req = 0; ext_we = 0; ext_addr = '0; ext_wdata = '0; ext_last = 0;

    // Reset, then idle
    cyc(1'b1, 0, 0, 19'h0, 19'h0, 0, 0, 19'h0, 19'h0, 0);
    cyc(1'b0, 0, 0, 19'h0, 19'h0, 0, 0, 19'h0, 19'h0, 0);
    check_eq("rst_stall", 32'(obs_stall), 32'd0);
    check_eq("rst_gnt",   32'(obs_gnt),   32'd0);
    check_eq("rst_we",    32'(obs_we),    32'd0);
    check_eq("rst_rvalid", 32'(ext_rvalid), 32'd0);
    check_eq("rst_rdata",  32'(ext_rdata),  32'd0);

    // CPU write then read back
    cyc(0, 1, 1, 19'h00010, 19'h1ABCD, 0, 0, 19'h0, 19'h0, 0);
    check_eq("cpu_wr_we", 32'(obs_we), 32'd1);
    cyc(0, 1, 0, 19'h00010, 19'h0, 0, 0, 19'h0, 19'h0, 0);
    check_eq("cpu_rd_we",    32'(obs_we),    32'd0);
    check_eq("cpu_rd_data",  32'(obs_rdata), 32'h1ABCD);
    check_eq("cpu_rd_stall", 32'(obs_stall), 32'd0);

    // Opportunistic external read
    cyc(0, 0, 0, 19'h0, 19'h0, 1, 0, 19'h00020, 19'h0, 0);
    check_eq("opp_gnt",    32'(obs_gnt),    32'd1);
    check_eq("opp_rvalid", 32'(ext_rvalid), 32'd1);
    check_eq("opp_rdata",  32'(ext_rdata),  32'h00055);
    cyc(0, 0, 0, 19'h0, 19'h0, 0, 0, 19'h0, 19'h0, 0);

    // Continuous contention: 8 denials, 4-grant window, CPU back
    for (int i = 0; i < 13; i++) begin
      cyc(0, 1, 0, 19'h00011, 19'h0, 1, 0, 19'(8'h20 + i), 19'h0, 0);
      check_eq("starve_gnt",   32'(obs_gnt),   32'(i >= 8 && i < 12));
      check_eq("starve_stall", 32'(obs_stall), 32'(i >= 8 && i < 12));
    end
    cyc(0, 0, 0, 19'h0, 19'h0, 0, 0, 19'h0, 19'h0, 0);

    // Window ended by ext_last on the second write
    starve(1'b1);
    n_w = 0; n_s = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 19'h00012, 19'h0, 1, 1, 19'(8'h60 + i), 19'(19'h7000 + i), 1'(i == 1));
      n_w += int'(obs_we);
      n_s += int'(obs_stall);
    end
    check_eq("last_writes", 32'(n_w), 32'd2);
    check_eq("last_stalls", 32'(n_s), 32'd2);
    check_eq("last_resume", 32'(obs_stall), 32'd0);
    cyc(0, 0, 0, 19'h0, 19'h0, 0, 0, 19'h0, 19'h0, 0);

    // Window ended by ext_req dropping after one grant
    starve(1'b0);
    cyc(0, 1, 0, 19'h00013, 19'h0, 1, 1, 19'h00070, 19'h12345, 0);
    check_eq("drop_gnt1", 32'(obs_gnt), 32'd1);
    cyc(0, 1, 0, 19'h00013, 19'h0, 0, 0, 19'h0, 19'h0, 0);
    check_eq("drop_idle_stall", 32'(obs_stall), 32'd1);
    check_eq("drop_idle_we",    32'(obs_we),    32'd0);
    check_eq("drop_idle_gnt",   32'(obs_gnt),   32'd0);
    cyc(0, 1, 0, 19'h00013, 19'h0, 0, 0, 19'h0, 19'h0, 0);
    check_eq("drop_resume", 32'(obs_stall), 32'd0);

    // Reset mid-window with a read granted in the reset cycle
    starve(1'b0);
    cyc(0, 1, 0, 19'h00014, 19'h0, 1, 0, 19'h00021, 19'h0, 0);
    cyc(1, 1, 0, 19'h00014, 19'h0, 1, 0, 19'h00020, 19'h0, 0);
    check_eq("rstwin_gnt",    32'(obs_gnt),    32'd1);
    check_eq("rstwin_rvalid", 32'(ext_rvalid), 32'd0);
    for (int i = 0; i < int'(MAX_WAIT) + 1; i++) begin
      cyc(0, 1, 0, 19'h00014, 19'h0, 1, 0, 19'h00022, 19'h0, 0);
      check_eq("rstwin_gnt_after",   32'(obs_gnt),   32'(i == int'(MAX_WAIT)));
      check_eq("rstwin_stall_after", 32'(obs_stall), 32'(i == int'(MAX_WAIT)));
    end
    cyc(0, 0, 0, 19'h0, 19'h0, 0, 0, 19'h0, 19'h0, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic r, cr, cw, er, ew, el;
      r  = 1'($urandom_range(0, 99) == 0);
      cr = 1'($urandom_range(0, 99) < 70);
      cw = 1'($urandom_range(0, 1));
      er = 1'($urandom_range(0, 99) < 65);
      ew = 1'($urandom_range(0, 1));
      el = 1'($urandom_range(0, 99) < 20);
      cyc(r, cr, cw, 19'($urandom_range(0, 255)), 19'($urandom),
          er, ew, 19'($urandom_range(0, 255)), 19'($urandom), el);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
